// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with a register-file writeback handshake.
// Optional two's-complement support is enabled by defining MULDIV_SIGNED_EN (adds op_signed port).
module muldiv_unit #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [WIDTH-1:0]  operand_a,
   input  logic [WIDTH-1:0]  operand_b,
   input  logic [ADDR_W-1:0] dest,
`ifdef MULDIV_SIGNED_EN
   input  logic              op_signed,
`endif
   output logic              busy,
   output logic              wb_req,
   input  logic              wb_grant,
   output logic [ADDR_W-1:0] wb_dest,
   output logic [WIDTH-1:0]  wb_data
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

   state_t              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [ADDR_W-1:0]   dest_q, dest_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0]    hi_q, hi_d;
   logic [WIDTH-1:0]    lo_q, lo_d;
   logic [WIDTH-1:0]    rem_q, rem_d;
   logic                neg_q, neg_d;
   logic                busy_q, busy_d;
   logic                wb_req_q, wb_req_d;
   logic [ADDR_W-1:0]   wb_dest_q, wb_dest_d;
   logic [WIDTH-1:0]    wb_data_q, wb_data_d;

   logic                sgn, a_neg, b_neg;
   logic [WIDTH-1:0]    a_mag, b_mag;
   logic [WIDTH:0]      mul_sum;
   logic [WIDTH-1:0]    mul_hi, mul_lo;
   logic [WIDTH:0]      rem_sh;
   logic                div_ge;
   logic [WIDTH-1:0]    div_rem, div_lo;
   logic [2*WIDTH-1:0]  prod;
   logic [WIDTH-1:0]    quo, rmd, result;

`ifdef MULDIV_SIGNED_EN
   assign sgn = op_signed;
`else
   assign sgn = 1'b0;
`endif

   always_comb begin
      // Datapath works on magnitudes; the sign is reapplied as the result is registered.
      a_neg = sgn & operand_a[WIDTH-1];
      b_neg = sgn & operand_b[WIDTH-1];
      a_mag = a_neg ? (~operand_a + WIDTH'(1)) : operand_a;
      b_mag = b_neg ? (~operand_b + WIDTH'(1)) : operand_b;

      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
      mul_hi  = mul_sum[WIDTH:1];
      mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

      // WIDTH+1-bit trial remainder; a failed trial leaves it below the divisor.
      rem_sh  = {rem_q, lo_q[WIDTH-1]};
      div_ge  = (rem_sh >= {1'b0, mcand_q});
      div_rem = div_ge ? WIDTH'(rem_sh - {1'b0, mcand_q}) : rem_sh[WIDTH-1:0];
      div_lo  = {lo_q[WIDTH-2:0], div_ge};

      prod = neg_q ? (~{mul_hi, mul_lo} + (2*WIDTH)'(1)) : {mul_hi, mul_lo};
      quo  = neg_q ? (~div_lo + WIDTH'(1)) : div_lo;
      rmd  = neg_q ? (~div_rem + WIDTH'(1)) : div_rem;
      unique case (op_q)
         2'b00:   result = prod[WIDTH-1:0];
         2'b01:   result = prod[2*WIDTH-1:WIDTH];
         2'b10:   result = quo;
         default: result = rmd;
      endcase

      state_d   = state_q;
      op_d      = op_q;
      dest_d    = dest_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      rem_d     = rem_q;
      neg_d     = neg_q;
      wb_dest_d = wb_dest_q;
      wb_data_d = wb_data_q;

      case (state_q)
         IDLE: if (start) begin
            op_d   = op;
            dest_d = dest;
            neg_d  = (op == 2'b11) ? a_neg : (a_neg ^ b_neg);
            if (op[1] && operand_b == '0) begin
               state_d   = WB;
               wb_dest_d = dest;
               wb_data_d = op[0] ? operand_a : '1;
            end else begin
               state_d = CALC;
               cnt_d   = CW'(WIDTH-1);
               mcand_d = op[1] ? b_mag : a_mag;
               lo_d    = op[1] ? a_mag : b_mag;
               hi_d    = '0;
               rem_d   = '0;
            end
         end
         CALC: begin
            cnt_d = cnt_q - CW'(1);
            if (op_q[1]) begin
               rem_d = div_rem;
               lo_d  = div_lo;
            end else begin
               hi_d = mul_hi;
               lo_d = mul_lo;
            end
            if (cnt_q == '0) begin
               state_d   = WB;
               wb_data_d = result;
               wb_dest_d = dest_q;
            end
         end
         WB: if (wb_grant) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d   = (state_d != IDLE);
      wb_req_d = (state_d == WB);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= '0;
         dest_q    <= '0;
         cnt_q     <= '0;
         mcand_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         rem_q     <= '0;
         neg_q     <= 1'b0;
         busy_q    <= 1'b0;
         wb_req_q  <= 1'b0;
         wb_dest_q <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         dest_q    <= dest_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         rem_q     <= rem_d;
         neg_q     <= neg_d;
         busy_q    <= busy_d;
         wb_req_q  <= wb_req_d;
         wb_dest_q <= wb_dest_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign busy    = busy_q;
   assign wb_req  = wb_req_q;
   assign wb_dest = wb_dest_q;
   assign wb_data = wb_data_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit for the 16-bit RISC core.
- Takes operands from the register file read ports and a destination register number.
- Computes over multiple cycles, then requests the register file write port to retire the result.
- Sits between the GPR read ports (upstream) and the GPR write port mux (downstream), in parallel with the single-cycle ALU.

Parameters:
- WIDTH, 16, operand/result width; iteration count equals WIDTH.
- ADDR_W, 4, destination register address width; matches the register file write port.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; returns block to IDLE.
- start  input  1  issue pulse; accepted only when busy=0.
- op  input  2  00 MUL low, 01 MULH high, 10 DIV quotient, 11 REM remainder.
- operand_a  input  WIDTH  multiplicand / dividend (GPR read data 1).
- operand_b  input  WIDTH  multiplier / divisor (GPR read data 2).
- dest  input  ADDR_W  destination register number.
- busy  output  1  high from the cycle after start accept until the writeback handshake completes.
- wb_req  output  1  result valid, requesting the GPR write port.
- wb_grant  input  1  write port granted this cycle; the register file captures the write on the same edge.
- wb_dest  output  ADDR_W  register number to write.
- wb_data  output  WIDTH  result to write.

Behaviour:
- Reset: state=IDLE; busy=0, wb_req=0, wb_dest=0, wb_data=0; counter and working registers cleared.
- Reset asserted mid-operation aborts the operation immediately. No write request is issued for it.
- States: IDLE, CALC, WB.
- IDLE to CALC:
  - Condition: start=1.
  - Latches op, dest, operand_a, operand_b. Loads counter=WIDTH-1. busy=1 next cycle.
- IDLE to WB (divide-by-zero shortcut):
  - Condition: start=1, op[1]=1, operand_b=0.
  - Skips CALC. Result: DIV gives all ones (0xFFFF); REM gives operand_a.
- Multiply:
  - Shift-add, one multiplier bit per cycle.
  - Unsigned 2*WIDTH-bit product in {hi, lo} working registers.
  - MUL returns lo; MULH returns hi.
- Divide:
  - Restoring division, one quotient bit per cycle.
  - Remainder register is WIDTH+1 bits for the trial subtract.
  - DIV returns quotient; REM returns remainder.
- CALC:
  - Counter decrements each cycle.
  - When counter=0 at the clock edge, go to WB; wb_data and wb_dest are registered on that same edge.
- Latency: start accepted at edge N gives wb_req=1 after edge N+WIDTH (16 cycles); 1 cycle on the divide-by-zero shortcut.
- WB:
  - wb_req=1; wb_data and wb_dest held stable while wb_grant=0, with no limit on stall length.
  - On an edge with wb_grant=1: go to IDLE, wb_req=0 and busy=0 next cycle.
  - wb_data and wb_dest keep their last values after retirement.
- start while busy=1 is ignored: no queueing, operands not relatched. The issue logic must stall on busy.
- wb_grant while wb_req=0 has no effect.
- start in the cycle that wb_grant retires a result is ignored. A new start is accepted from IDLE on the next cycle.
- Back-to-back issue: minimum WIDTH+2 cycles between accepted starts when grant is immediate.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - Adds input port op_signed (1 bit), latched with start.
  - When op_signed=1, operands are treated as two's complement. Magnitudes are taken at accept and the result sign is fixed in the WB-entry cycle, with no extra latency.
  - MULH returns the signed high half.
  - DIV truncates toward zero; REM takes the sign of the dividend.
  - Overflow case 0x8000 / 0xFFFF: quotient 0x8000, remainder 0.
  - Divide-by-zero results are unchanged from the unsigned case.
- Not defined: op_signed port absent; all operations unsigned.

Test Plan:
- MUL 0x1234 * 0x0010, dest=3, wb_grant tied 1 -> wb_req rises exactly 16 cycles after start; wb_data=0x2340, wb_dest=3; busy clears next cycle.
- MULH 0xFFFF * 0xFFFF -> 0xFFFE. MUL of the same operands -> 0x0001.
- DIV 1000/7 -> 0x008E; REM 1000/7 -> 0x0006. DIV 5/0 -> 0xFFFF after 1 cycle; REM 5/0 -> 0x0005.
- Hold wb_grant=0 for 10 cycles in WB -> wb_req, wb_data and wb_dest stable; start pulses during the stall ignored; single retire on the first grant.
- Assert reset at cycle 8 of a DIV -> busy=0, wb_req=0 immediately and no writeback appears; a fresh MUL 3*4 afterwards -> 0x000C.
- With MULDIV_SIGNED_EN: DIV -7/2 -> 0xFFFD; REM -7/2 -> 0xFFFF; DIV 0x8000/0xFFFF -> 0x8000; MULH -2*3 -> 0xFFFF.
